// File: rtl/cache_pkg.sv
// Shared types and helpers for the instruction-cache fetch sequencer.
package cache_pkg;

  localparam int SET_W_DEF = 2;
  localparam int CNT_W     = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_CHECK   = 3'd2,
    S_MM_WAIT = 3'd3,
    S_FILL    = 3'd4,
    S_RESP    = 3'd5
  } fetch_state_e;

  // Tag portion of a fetch address: PC[31:set_w+2].
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int set_w);
    return pc >> (set_w + 2);
  endfunction

  // Set index of a fetch address: PC[set_w+1:2], zero-extended to 8 bits.
  function automatic logic [7:0] pc_set(input logic [31:0] pc, input int set_w);
    return 8'((pc >> 2) & ((32'd1 << set_w) - 32'd1));
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with increment enable and asynchronous clear.
module sat_cnt #(
  parameter int W = 20
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Count up on enable, stick at all-ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fetch_ctrl.sv
// Fetch-side sequencer for the 2-way instruction cache: lookup, miss refill
// from main memory with timeout, response to the CPU, and stall/refill counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a fetch request
// LOOKUP    | pc_q presented to the cache, cache evaluates this cycle
// CHECK     | registered hit/miss available; hit -> RESP, miss -> MM_WAIT
// MM_WAIT   | main-memory read outstanding, timeout counter running
// FILL      | one-cycle refill strobe into the cache
// RESP      | one-cycle response pulse to the CPU
module cache_fetch_ctrl
  import cache_pkg::*;
#(
  parameter int SET_W = SET_W_DEF,
  parameter int TMO   = 255
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CPU_REQ,
  input  logic [31:0]      CPU_PC,
  output logic             CPU_READY,
  output logic             CPU_VALID,
  output logic [31:0]      CPU_INSTR,
  output logic             CPU_ERR,
  output logic [31:0]      C_PC,
  output logic [SET_W-1:0] C_SET,
  output logic             C_ACCESS_MM,
  output logic [31:0]      C_DATA_MM,
  input  logic             C_HIT,
  input  logic [31:0]      C_DATA,
  output logic             MM_REQ,
  output logic [31:0]      MM_ADDR,
  input  logic             MM_ACK,
  input  logic [31:0]      MM_RDATA,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] REFILL_CNT
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, instr_q, data_mm_q;
  logic         err_q;
  logic [7:0]   tmo_q;
  logic         tmo_hit;

  // The wait that would bring the counter to TMO is the last one allowed.
  assign tmo_hit = ({1'b0, tmo_q} + 9'd1) == 9'(TMO);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; an ack in the limit cycle takes priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (CPU_REQ) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = S_CHECK;
      S_CHECK:   state_d = C_HIT ? S_RESP : S_MM_WAIT;
      S_MM_WAIT: begin
        if (MM_ACK)       state_d = S_FILL;
        else if (tmo_hit) state_d = S_RESP;
      end
      S_FILL:    state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Transaction datapath: PC latch, instruction/refill capture, timeout and error.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q      <= '0;
      instr_q   <= '0;
      data_mm_q <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (CPU_REQ) pc_q <= CPU_PC;
        S_CHECK: begin
          tmo_q <= '0;
          if (C_HIT) instr_q <= C_DATA;
        end
        S_MM_WAIT: begin
          if (MM_ACK) begin
            instr_q   <= MM_RDATA;
            data_mm_q <= MM_RDATA;
          end else begin
            tmo_q <= tmo_q + 8'd1;
            if (tmo_hit) err_q <= 1'b1;
          end
        end
        S_RESP:  err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign CPU_READY   = (state_q == S_IDLE);
  assign CPU_VALID   = (state_q == S_RESP);
  assign CPU_INSTR   = instr_q;
  assign CPU_ERR     = (state_q == S_RESP) && err_q;
  assign C_PC        = pc_q;
  assign C_SET       = SET_W'(pc_set(pc_q, SET_W));
  assign C_ACCESS_MM = (state_q == S_FILL);
  assign C_DATA_MM   = data_mm_q;
  assign MM_REQ      = (state_q == S_MM_WAIT);
  assign MM_ADDR     = {pc_q[31:2], 2'b00};

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (state_q != S_IDLE),
    .cnt     (STALL_CNT)
  );

  sat_cnt #(.W(CNT_W)) u_refill_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     ((state_q == S_MM_WAIT) && MM_ACK),
    .cnt     (REFILL_CNT)
  );

endmodule

// File: tb/tb_cache_fetch_ctrl.sv
// Bench for cache_fetch_ctrl: directed and random fetches against a
// transaction-level latency/counter model.
module tb_cache_fetch_ctrl;

  localparam int SET_W = 2;
  localparam int TMO   = 4;
  localparam logic [19:0] CNT_MAX = 20'hFFFFF;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             CPU_REQ = 1'b0;
  logic [31:0]      CPU_PC = '0;
  logic             CPU_READY, CPU_VALID, CPU_ERR;
  logic [31:0]      CPU_INSTR, C_PC, C_DATA_MM, MM_ADDR;
  logic [SET_W-1:0] C_SET;
  logic             C_ACCESS_MM, MM_REQ;
  logic             C_HIT = 1'b0;
  logic [31:0]      C_DATA = '0;
  logic             MM_ACK = 1'b0;
  logic [31:0]      MM_RDATA = '0;
  logic [19:0]      STALL_CNT, REFILL_CNT;

  int checks = 0;
  int errors = 0;

  // Reference model state: totals of the counters and last refill word.
  longint model_stall  = 0;
  longint model_refill = 0;
  logic [31:0] model_dmm = '0;

  cache_fetch_ctrl #(.SET_W(SET_W), .TMO(TMO)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_PC(CPU_PC), .CPU_READY(CPU_READY),
    .CPU_VALID(CPU_VALID), .CPU_INSTR(CPU_INSTR), .CPU_ERR(CPU_ERR),
    .C_PC(C_PC), .C_SET(C_SET), .C_ACCESS_MM(C_ACCESS_MM), .C_DATA_MM(C_DATA_MM),
    .C_HIT(C_HIT), .C_DATA(C_DATA),
    .MM_REQ(MM_REQ), .MM_ADDR(MM_ADDR), .MM_ACK(MM_ACK), .MM_RDATA(MM_RDATA),
    .STALL_CNT(STALL_CNT), .REFILL_CNT(REFILL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint b);
    return (a + b > longint'(CNT_MAX)) ? longint'(CNT_MAX) : a + b;
  endfunction

  // One fetch. ack_delay = number of MM_REQ cycles before the ack (>= TMO: never).
  task automatic run_txn(input logic [31:0] pc, input logic hit, input logic [31:0] cdata,
                         input int ack_delay, input logic [31:0] rdata);
    int cyc, vcyc, req_cycles, pulses, exp_lat, exp_req;
    logic vseen, verr, pc_ok, set_ok, addr_ok, exp_fill, exp_err;
    logic [31:0] vinstr, dmm, exp_instr;
    cyc = 0; vcyc = 0; req_cycles = 0; pulses = 0;
    vseen = 0; verr = 0; pc_ok = 1; set_ok = 1; addr_ok = 1;
    vinstr = '0; dmm = '0;

    // Model: latency and effects straight from the fetch rules.
    exp_fill = !hit && (ack_delay < TMO);
    exp_err  = !hit && (ack_delay >= TMO);
    if (hit)           begin exp_lat = 3;             exp_instr = cdata; exp_req = 0;         end
    else if (exp_fill) begin exp_lat = 5 + ack_delay; exp_instr = rdata; exp_req = ack_delay + 1; end
    else               begin exp_lat = TMO + 3;       exp_instr = '0;    exp_req = TMO;       end

    @(negedge CLK);
    CPU_REQ = 1'b1; CPU_PC = pc; C_HIT = hit; C_DATA = cdata; MM_ACK = 1'b0;
    @(posedge CLK);
    #1 CPU_REQ = 1'b0; CPU_PC = $urandom;
    while (!vseen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      MM_ACK = 1'b0;
      if (C_PC !== pc) pc_ok = 0;
      if (C_SET !== SET_W'((pc >> 2) % (1 << SET_W))) set_ok = 0;
      if (MM_REQ) begin
        if (MM_ADDR !== (pc & 32'hFFFF_FFFC)) addr_ok = 0;
        if (req_cycles == ack_delay) begin MM_ACK = 1'b1; MM_RDATA = rdata; end
        req_cycles++;
      end
      if (C_ACCESS_MM) begin pulses++; dmm = C_DATA_MM; end
      if (CPU_VALID) begin vseen = 1; vcyc = cyc; vinstr = CPU_INSTR; verr = CPU_ERR; end
    end
    MM_ACK = 1'b0;
    @(posedge CLK);
    #1;

    model_stall  = sat_add(model_stall, exp_lat);
    model_refill = sat_add(model_refill, exp_fill ? 1 : 0);
    if (exp_fill) model_dmm = rdata;

    chk("valid_cycle", 32'(vcyc), 32'(exp_lat));
    chk("cpu_err", {31'd0, verr}, {31'd0, exp_err});
    if (!exp_err) chk("cpu_instr", vinstr, exp_instr);
    chk("fill_pulses", 32'(pulses), exp_fill ? 32'd1 : 32'd0);
    if (exp_fill) chk("fill_data", dmm, rdata);
    chk("mm_req_cycles", 32'(req_cycles), 32'(exp_req));
    if (!hit) chk("mm_addr", {31'd0, addr_ok}, 32'd1);
    chk("c_pc_stable", {31'd0, pc_ok}, 32'd1);
    chk("c_set", {31'd0, set_ok}, 32'd1);
    chk("stall_cnt", {12'd0, STALL_CNT}, 32'(model_stall));
    chk("refill_cnt", {12'd0, REFILL_CNT}, 32'(model_refill));
    chk("c_data_mm_hold", C_DATA_MM, model_dmm);
    chk("ready_after", {31'd0, CPU_READY}, 32'd1);
  endtask

  initial begin
    int any_valid, any_fill;

    // Reset values while held in reset.
    #2;
    chk("rst_ready", {31'd0, CPU_READY}, 32'd1);
    chk("rst_valid", {31'd0, CPU_VALID}, 32'd0);
    chk("rst_err", {31'd0, CPU_ERR}, 32'd0);
    chk("rst_mm_req", {31'd0, MM_REQ}, 32'd0);
    chk("rst_access", {31'd0, C_ACCESS_MM}, 32'd0);
    chk("rst_stall", {12'd0, STALL_CNT}, 32'd0);
    chk("rst_refill", {12'd0, REFILL_CNT}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Directed: hit, miss with ack on second wait cycle, timeout, ack at limit.
    run_txn(32'h0000_0010, 1'b1, 32'hAABB_CCDD, 0, 32'h0);
    run_txn(32'h0000_0024, 1'b0, 32'hDEAD_0000, 1, 32'h1234_5678);
    run_txn(32'h0000_0100, 1'b0, 32'h0, 99, 32'hFFFF_0000);
    run_txn(32'h0000_0a0c, 1'b0, 32'h0, TMO - 1, 32'h0BAD_F00D);

    // Random fetches.
    for (int i = 0; i < 24; i++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)), $urandom);
    end

    // Reset in the middle of a memory wait, then a stray ack in IDLE.
    @(negedge CLK);
    CPU_REQ = 1'b1; CPU_PC = 32'h0000_0400; C_HIT = 1'b0; MM_ACK = 1'b0;
    @(posedge CLK);
    #1 CPU_REQ = 1'b0;
    repeat (4) @(negedge CLK);
    chk("pre_rst_mm_req", {31'd0, MM_REQ}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, CPU_READY}, 32'd1);
    chk("mid_rst_mm_req", {31'd0, MM_REQ}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1; MM_ACK = 1'b1; MM_RDATA = 32'hCAFE_BABE;
    any_valid = 0; any_fill = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      MM_ACK = 1'b0;
      if (CPU_VALID) any_valid++;
      if (C_ACCESS_MM) any_fill++;
    end
    model_stall = 0; model_refill = 0; model_dmm = '0;
    chk("post_rst_valid", 32'(any_valid), 32'd0);
    chk("post_rst_fill", 32'(any_fill), 32'd0);
    chk("post_rst_ready", {31'd0, CPU_READY}, 32'd1);
    chk("post_rst_stall", {12'd0, STALL_CNT}, 32'(model_stall));
    chk("post_rst_refill", {12'd0, REFILL_CNT}, 32'(model_refill));
    chk("post_rst_dmm", C_DATA_MM, model_dmm);

    // Stall counter saturation from a preloaded value.
    @(negedge CLK);
    force dut.u_stall_cnt.cnt_q = 20'hFFFFE;
    #1 release dut.u_stall_cnt.cnt_q;
    model_stall = 64'h0_FFFFE;
    run_txn(32'h0000_0010, 1'b1, 32'h1111_2222, 0, 32'h0);
    chk("stall_sat", {12'd0, STALL_CNT}, 32'h000F_FFFF);
    run_txn(32'h0000_0014, 1'b1, 32'h3333_4444, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fetch_ctrl.md
# cache_fetch_ctrl

Fetch-side sequencer for the 2-way instruction cache.
- Accepts one instruction request at a time from the CPU fetch stage and holds the PC stable at the cache.
- Reads the registered hit/miss result and, on a miss, runs a main-memory read with timeout, then issues a one-cycle refill (`Access_MM`) into the cache.
- Returns the instruction to the CPU, and keeps saturating stall and refill counters for performance measurement.

## Interface
Parameters:
- `SET_W`, 2: set index width; the set is `PC[SET_W+1:2]`. Values: 2 for 8 entries, 3 for 16, 4 for 32.
- `TMO`, 255: maximum number of cycles in MM_WAIT without `MM_ACK` before an error response. Range 1..255.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset. The cache's active-high `RESET` is driven from `!RESET_N` at integration.
- `CPU_REQ` in 1: fetch request; sampled only when `CPU_READY`=1.
- `CPU_PC` in 32: fetch address; word aligned, bits [1:0] ignored.
- `CPU_READY` out 1: high exactly in IDLE.
- `CPU_VALID` out 1: one-cycle response pulse.
- `CPU_INSTR` out 32: instruction; valid only while `CPU_VALID`=1.
- `CPU_ERR` out 1: qualifies `CPU_VALID`; set on memory timeout.
- `C_PC` out 32: PC driven to the cache.
- `C_SET` out SET_W: set index driven to the cache.
- `C_ACCESS_MM` out 1: refill strobe to the cache (`Access_MM`).
- `C_DATA_MM` out 32: refill data to the cache (`Data_MM`).
- `C_HIT` in 1: cache `HitWrite`.
- `C_DATA` in 32: cache `Data_Cache`.
- `MM_REQ` out 1: main-memory read request; level signal, held until acknowledged.
- `MM_ADDR` out 32: main-memory read address, `{pc_q[31:2],2'b00}`.
- `MM_ACK` in 1: one-cycle read acknowledge; `MM_RDATA` is valid in the same cycle.
- `MM_RDATA` in 32: main-memory read data.
- `STALL_CNT` out 20: count of cycles spent outside IDLE; saturating.
- `REFILL_CNT` out 20: count of accepted `MM_ACK`s; saturating.

## Operation
Registered state machine with states IDLE, LOOKUP, CHECK, MM_WAIT, FILL, RESP.

- **IDLE**: `CPU_READY`=1. If `CPU_REQ`=1, latch `pc_q`=`CPU_PC` and go to LOOKUP.
- **LOOKUP**: `C_PC`=`pc_q` and `C_SET`=`pc_q[SET_W+1:2]`; the cache evaluates at the end of this cycle. Go to CHECK unconditionally.
- **CHECK**:
  - `C_HIT`=1: capture `C_DATA` into `instr_q`, go to RESP.
  - `C_HIT`=0: clear the timeout counter, go to MM_WAIT.
- **MM_WAIT**: `MM_REQ`=1.
  - `MM_ACK`=1: capture `MM_RDATA` into `instr_q` and `C_DATA_MM`, increment `REFILL_CNT`, go to FILL.
  - Otherwise the timeout counter increments. When it reaches `TMO`, set `err_q`, drop `MM_REQ`, and go to RESP without a fill.
  - If `MM_ACK` arrives in the same cycle the counter reaches `TMO`, the ack wins.
- **FILL**: `C_ACCESS_MM`=1 for exactly one cycle; the cache writes its LRU way. Go to RESP.
- **RESP**: `CPU_VALID`=1, `CPU_INSTR`=`instr_q`, `CPU_ERR`=`err_q`. Clear `err_q` and go to IDLE. The response is not back-pressured.

Hold rules:
- `C_PC` and `C_SET` always come from `pc_q`, so they stay stable from LOOKUP through RESP.
- `C_DATA_MM` holds its last captured value.

Counters:
- Both counters saturate at 20'hFFFFF.
- `STALL_CNT` increments in every cycle where the state is not IDLE.

Reset (asynchronous, `RESET_N`=0):
- State goes to IDLE; `pc_q`, `instr_q`, `err_q`, `C_DATA_MM`, the timeout counter, `STALL_CNT` and `REFILL_CNT` all clear to 0.
- Output values during and after reset: `CPU_READY`=1; `CPU_VALID`, `CPU_ERR`, `MM_REQ` and `C_ACCESS_MM` are all 0.
- If reset lands mid-transaction, the transaction is abandoned. No fill is issued, and a late `MM_ACK` seen in IDLE is ignored.

## Timing
- Hit: `CPU_REQ` accepted at edge 0; `CPU_VALID` is high in cycle 3 (IDLE→LOOKUP→CHECK→RESP).
- Miss with `MM_ACK` in the first MM_WAIT cycle: `CPU_VALID` is high in cycle 5. Each extra memory wait cycle adds 1.
- Timeout: `CPU_VALID` with `CPU_ERR` is high `TMO`+3 cycles after acceptance.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP.
- All outputs are decoded from registered state and registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cache_pkg` holds:
  - the state enum;
  - `SET_W_DEF`;
  - tag and set slicing helpers (tag = `PC[31:SET_W+2]`);
  - the counter width `CNT_W`=20.
- One sub-module, `sat_cnt`: parameterized width, increment enable, asynchronous active-low clear. It is instantiated twice, once per counter.

## Test plan
- Reset, then hit at PC 0x0000_0010 with the cache returning `C_HIT`=1 and `C_DATA`=0xAABB_CCDD in CHECK → `CPU_VALID` in cycle 3, `CPU_INSTR`=0xAABB_CCDD, `STALL_CNT`=3, `REFILL_CNT`=0.
- Miss at PC 0x0000_0024 with `MM_ACK` 2 cycles after `MM_REQ` rises and `MM_RDATA`=0x1234_5678 →
  - `MM_ADDR`=0x0000_0024;
  - one `C_ACCESS_MM` pulse with `C_DATA_MM`=0x1234_5678;
  - `CPU_INSTR`=0x1234_5678 in cycle 6;
  - `REFILL_CNT`=1.
- Timeout with `TMO`=4 and no `MM_ACK` → `MM_REQ` drops after 4 cycles, `CPU_VALID`=1 with `CPU_ERR`=1 in cycle 7, no `C_ACCESS_MM` pulse.
- `MM_ACK` in the same cycle as the timeout limit with `TMO`=4 → fill occurs and `CPU_ERR`=0.
- `RESET_N` pulsed low during MM_WAIT, then `MM_ACK` arrives in IDLE → `CPU_READY`=1, no `CPU_VALID`, no fill, counters at 0.
- `STALL_CNT` preloaded via force to 20'hFFFFE, then 3 stall cycles → `STALL_CNT`=20'hFFFFF and holds.
